// File: rtl/aclrx_rdsched.sv
// Host-side read scheduler for the ACL rx buffer: fetches, presents and releases one packet per visit.
// Optional packet counter output enabled by defining ACLRX_PKTCNT_EN.
module aclrx_rdsched (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic        regi_aclrxbufempty,
    input  logic [9:0]  rx_pylenByte,
    input  logic [31:0] bsm_dout,
    input  logic        host_rready,
    input  logic        flush_req,
    output logic [7:0]  bsm_addr,
    output logic        bsm_cs,
    output logic        bsm_valid_p,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        host_rlast,
    output logic [3:0]  host_rbe,
    output logic        busy
`ifdef ACLRX_PKTCNT_EN
    ,
    output logic [15:0] regi_aclrxpktcnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_PRES,
        S_FGAP,
        S_REL,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_len_lo;
    logic [7:0]  r_widx;
    logic [7:0]  r_last;
    logic [31:0] r_rdata;

    logic [10:0] w_len_round;
    logic [8:0]  w_words;
    logic [7:0]  w_last_calc;
    logic        w_hs;
    logic        w_is_last;
    logic        w_start;

    // len==0 yields last=8'hFF, which doubles as the empty-packet release address
    assign w_len_round = 11'(rx_pylenByte) + 11'd3;
    assign w_words     = w_len_round[10:2];
    assign w_last_calc = 8'(w_words - 9'd1);

    assign w_start   = (r_state == S_IDLE) && !regi_aclrxbufempty;
    assign w_hs      = (r_state == S_PRES) && host_rready;
    assign w_is_last = (r_widx == r_last);

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        bsm_cs       = 1'b0;
        bsm_addr     = 8'h00;
        bsm_valid_p  = 1'b0;
        host_rvalid  = 1'b0;
        host_rlast   = 1'b0;
        host_rbe     = 4'b0000;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (!regi_aclrxbufempty) begin
                    w_state_next = (flush_req || (rx_pylenByte == 10'd0)) ? S_REL : S_RD;
                end
            end
            S_RD: begin
                bsm_cs       = 1'b1;
                bsm_addr     = r_widx;
                w_state_next = flush_req ? S_REL : S_WAIT;
            end
            S_WAIT: begin
                w_state_next = flush_req ? S_REL : S_PRES;
            end
            S_PRES: begin
                host_rvalid = 1'b1;
                host_rlast  = w_is_last;
                host_rbe    = 4'b1111;
                if (w_is_last) begin
                    case (r_len_lo)
                        2'b01:   host_rbe = 4'b0001;
                        2'b10:   host_rbe = 4'b0011;
                        2'b11:   host_rbe = 4'b0111;
                        default: host_rbe = 4'b1111;
                    endcase
                end
                if (host_rready) begin
                    bsm_valid_p = 1'b1;
                    bsm_addr    = r_widx;
                    if (w_is_last) begin
                        w_state_next = S_DONE;
                    end else if (flush_req) begin
                        // one idle cycle keeps the two release pulses apart
                        w_state_next = S_FGAP;
                    end else begin
                        w_state_next = S_RD;
                    end
                end else if (flush_req) begin
                    w_state_next = S_REL;
                end
            end
            S_FGAP: begin
                w_state_next = S_REL;
            end
            S_REL: begin
                bsm_valid_p  = 1'b1;
                bsm_addr     = r_last;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_len_lo <= 2'b00;
            r_widx   <= 8'h00;
            r_last   <= 8'h00;
            r_rdata  <= 32'h0;
        end else begin
            if (w_start) begin
                r_len_lo <= rx_pylenByte[1:0];
                r_widx   <= 8'h00;
                r_last   <= w_last_calc;
            end
            if (w_hs && !w_is_last) begin
                r_widx <= r_widx + 8'd1;
            end
            if (r_state == S_WAIT) begin
                r_rdata <= bsm_dout;
            end
        end
    end

    assign host_rdata = r_rdata;

`ifdef ACLRX_PKTCNT_EN
    logic [15:0] r_pktcnt;

    // only a completed last-word handshake counts as a delivered packet
    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            r_pktcnt <= 16'h0000;
        end else if (w_hs && w_is_last) begin
            r_pktcnt <= r_pktcnt + 16'd1;
        end
    end

    assign regi_aclrxpktcnt = r_pktcnt;
`endif

endmodule

// File: doc/aclrx_rdsched.md
ACLRX_RDSCHED -- requirements
Module: aclrx_rdsched

Interface
REQ-001 SHALL have ports clk_6M in 1 (sole clock, rising edge) and rst in 1 (asynchronous, active-high reset).
REQ-002 SHALL have input regi_aclrxbufempty, 1 bit: when 0, a received ACL packet is waiting in the rx buffer.
REQ-003 SHALL have input rx_pylenByte, 10 bits: byte length of the waiting packet.
REQ-004 SHALL have input bsm_dout, 32 bits: buffer read data, valid one cycle after bsm_cs.
REQ-005 SHALL have outputs bsm_addr (8 bits), bsm_cs (1 bit) and bsm_valid_p (1 bit: per-word consume pulse).
REQ-006 SHALL have outputs host_rdata (32 bits), host_rvalid, host_rlast and host_rbe (4 bits), plus input host_rready.
REQ-007 SHALL have input flush_req (1-cycle discard request) and output busy (1 when the FSM is not IDLE).

Function
REQ-008 SHALL implement the FSM states IDLE, RD, WAIT, PRES and DONE.
REQ-009 IDLE: regi_aclrxbufempty==0 SHALL latch rx_pylenByte into len, set word index widx=0 and set last=ceil(len/4)-1; the next state SHALL be RD.
REQ-010 IDLE with len==0: the FSM SHALL emit no host data, drive bsm_addr=8'hFF with one bsm_valid_p pulse and go to DONE.
REQ-011 RD: bsm_cs=1 and bsm_addr=widx for exactly one cycle, then WAIT.
REQ-012 WAIT: the FSM SHALL register bsm_dout into host_rdata, then go to PRES.
REQ-013 PRES: host_rvalid=1 SHALL hold with host_rdata stable until host_rready==1.
REQ-014 PRES: host_rlast SHALL be 1 iff widx==last.
REQ-015 host_rbe SHALL be 4'b1111 except on the last word, where len[1:0] gives 00->1111, 01->0001, 10->0011, 11->0111.
REQ-016 PRES handshake, not last: bsm_valid_p pulses one cycle with bsm_addr=widx, widx increments, then RD.
REQ-017 PRES handshake, last: bsm_valid_p pulses one cycle with bsm_addr=last, then DONE.
REQ-018 DONE SHALL last exactly one cycle, then IDLE, so a stale regi_aclrxbufempty==0 (registered upstream) is never resampled.
REQ-019 Throughput SHALL be one word per 3 cycles with host_rready tied to 1, i.e. first host_rvalid 3 cycles after IDLE detection.
REQ-020 flush_req in RD, WAIT or PRES SHALL drop host_rvalid the next cycle, drive bsm_addr=last with one bsm_valid_p pulse and go to DONE.
REQ-021 flush_req in PRES coincident with host_rready: the handshake SHALL complete first, followed by the flush release (bsm_addr=last).
REQ-022 flush_req in IDLE with a packet waiting SHALL release it without reads (bsm_addr=last with bsm_valid_p, or 8'hFF when len==0), then go to DONE.
REQ-023 flush_req in IDLE when the buffer is empty, or in DONE, SHALL be ignored.
REQ-024 bsm_valid_p SHALL never assert in two consecutive cycles.
REQ-025 bsm_cs SHALL never assert outside RD.
REQ-026 widx SHALL never exceed last, so 8-bit address wrap cannot occur for len<=1023 (last<=255).

Reset
REQ-027 rst SHALL asynchronously force state IDLE, outputs bsm_cs, bsm_valid_p, host_rvalid, host_rlast and busy to 0, bsm_addr to 0, host_rdata to 0 and host_rbe to 4'b0000.
REQ-028 rst asserted mid-packet SHALL abandon the packet with no bsm_valid_p; after release the FSM SHALL restart from IDLE.

Configuration
REQ-029 With macro ACLRX_PKTCNT_EN defined, the block SHALL add output regi_aclrxpktcnt (16 bits), reset to 0, which increments on each REQ-017 completion, wraps 16'hFFFF->0, and excludes flushes and len==0 releases.
REQ-030 Without ACLRX_PKTCNT_EN the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: len=8 with host_rready=1 -> 2 words at addr 0 and 1, host_rlast on word 1, host_rbe=1111 both, bsm_valid_p at addr 0 and 1, DONE, then IDLE.
REQ-032 Scenario: len=5 -> 2 words, last host_rbe=0001, release pulse at bsm_addr=1.
REQ-033 Scenario: len=0 -> no host_rvalid, single bsm_valid_p with bsm_addr=8'hFF, busy high for 2 cycles.
REQ-034 Scenario: len=16 with host_rready low 10 cycles on word 2, then flush_req -> host_rdata stable while stalled, host_rvalid drops, bsm_valid_p at bsm_addr=3, no further bsm_cs.
REQ-035 Scenario: rst pulse during WAIT of len=12 -> all outputs 0 asynchronously, no bsm_valid_p, fresh read from addr 0 after release.
REQ-036 Scenario with ACLRX_PKTCNT_EN defined: 3 packets plus 1 flushed -> regi_aclrxpktcnt=3.
